// File: rtl/eth_img_pkg.sv
// Shared definitions for the Sobel-to-UDP line path: header size, the read-side
// state encoding, the ping-pong bank index type and an address-width helper.
package eth_img_pkg;

    // Each payload starts with a big-endian 16-bit line index.
    localparam int HDR_BYTES = 2;

    // Read/transmit sequencer states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        HDR  = 3'd2,
        PAY  = 3'd3,
        REL  = 3'd4
    } rd_state_t;

    // Selects one of the two line banks.
    typedef logic bank_t;

    // Address width needed to index 'depth' entries, never less than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_pingpong_ram.sv
// Two banks of packed line bytes, one write port and one synchronous read port.
// Left without reset so it maps onto block RAM.
module line_pingpong_ram
    import eth_img_pkg::*;
#(
    parameter int DEPTH = 160,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  bank_t         wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  bank_t         rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [2][DEPTH];

    // Write packed pixel bytes into the selected bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Registered read: data appears one cycle after the address.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_bank][rd_addr];
    end

endmodule

// File: rtl/sobel_line_tx_scheduler.sv
// Packs the binary Sobel stream into per-line payloads held in a ping-pong buffer
// and hands each complete line to the UDP transmitter as index header + pixels.
module sobel_line_tx_scheduler
    import eth_img_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 720
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        valid,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        sobel,
    input  logic        tx_busy,
    input  logic        tx_data_req,
    output logic        tx_start,
    output logic [15:0] tx_len,
    output logic [7:0]  tx_data,
    output logic        line_drop,
    output logic        frame_done
);

    localparam int BYTES_PER_LINE = IMAGE_WIDTH / 8;
    localparam int DATA_LENGTH    = BYTES_PER_LINE + HDR_BYTES;
    localparam int PW             = addr_width(IMAGE_WIDTH);
    localparam int AW             = addr_width(BYTES_PER_LINE);

    localparam logic [PW-1:0] LAST_PIX  = PW'(IMAGE_WIDTH - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BYTES_PER_LINE - 1);
    localparam logic [15:0]   LAST_LINE = 16'(IMAGE_HEIGHT - 1);

    // Write side
    logic          hsync_d;
    logic          vsync_d;
    logic          hsync_rise;
    logic          vsync_rise;
    logic          short_line;
    logic          pix_step;
    logic [PW-1:0] pix_cnt;
    logic [PW-1:0] pix_base;
    logic [6:0]    shreg;
    logic          drop_line;
    logic          drop_now;
    logic [15:0]   line_idx;
    bank_t         wr_bank;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          line_end;
    logic          line_ok;

    // Shared bank bookkeeping
    logic [1:0]    bank_full;
    logic [15:0]   bank_idx [2];
    logic [1:0]    set_mask;
    logic [1:0]    clr_mask;

    // Read side
    rd_state_t     state;
    bank_t         rd_ptr;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] ram_addr;
    logic [7:0]    rd_data;
    logic          hdr_sel;
    logic          pay_req;
    logic          release_bank;

    assign tx_len = 16'(DATA_LENGTH);

    // Decode sync edges, the effective pixel position and the drop decision for this cycle.
    always_comb begin
        hsync_rise = hsync & ~hsync_d;
        vsync_rise = vsync & ~vsync_d;
        pix_step   = valid & ~vsync_rise;
        short_line = hsync_rise & ~vsync_rise & (pix_cnt != '0);
        pix_base   = hsync_rise ? '0 : pix_cnt;
        drop_now   = hsync_rise ? (bank_full[wr_bank] | ~enable) : drop_line;
        wr_en      = pix_step & ~drop_now & (pix_base[2:0] == 3'b111);
        wr_addr    = pix_base[PW-1:3];
        wr_data    = {shreg, sobel};
        line_end   = pix_step & (pix_base == LAST_PIX);
        line_ok    = line_end & ~drop_now;
    end

    // Pixel packer, line counter, drop tracking and write-bank rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_d     <= 1'b0;
            vsync_d     <= 1'b0;
            pix_cnt     <= '0;
            shreg       <= '0;
            drop_line   <= 1'b0;
            line_idx    <= '0;
            wr_bank     <= 1'b0;
            line_drop   <= 1'b0;
            bank_idx[0] <= '0;
            bank_idx[1] <= '0;
        end else begin
            hsync_d   <= hsync;
            vsync_d   <= vsync;
            line_drop <= 1'b0;
            if (vsync_rise) begin
                line_idx <= '0;
                pix_cnt  <= '0;
                shreg    <= '0;
            end else begin
                if (hsync_rise) begin
                    drop_line <= bank_full[wr_bank] | ~enable;
                end
                if (pix_step) begin
                    shreg   <= {shreg[5:0], sobel};
                    pix_cnt <= line_end ? '0 : pix_base + 1'b1;
                end else if (hsync_rise) begin
                    pix_cnt <= '0;
                    shreg   <= '0;
                end
                if (short_line || (line_end && drop_now)) begin
                    line_drop <= 1'b1;
                end
                if (short_line || line_end) begin
                    line_idx <= line_idx + 16'd1;
                end
                if (line_ok) begin
                    bank_idx[wr_bank] <= line_idx;
                    wr_bank           <= ~wr_bank;
                end
            end
        end
    end

    // Set/clear masks let a write completion and a read release land in the same cycle.
    always_comb begin
        set_mask = {line_ok & wr_bank, line_ok & ~wr_bank};
        clr_mask = {release_bank & rd_ptr, release_bank & ~rd_ptr};
    end

    // Full flags for both banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full <= '0;
        end else begin
            bank_full <= (bank_full & ~clr_mask) | set_mask;
        end
    end

    // Look ahead one address on a payload request so the next byte is already read.
    always_comb begin
        pay_req      = (state == PAY) & tx_data_req;
        release_bank = (state == REL);
        ram_addr     = (pay_req && rd_addr != LAST_ADDR) ? rd_addr + 1'b1 : rd_addr;
    end

    line_pingpong_ram #(
        .DEPTH (BYTES_PER_LINE),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_bank (rd_ptr),
        .rd_addr (ram_addr),
        .rd_data (rd_data)
    );

    // Transmit sequencer: request a frame, serve header then payload, release the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_ptr     <= 1'b0;
            rd_addr    <= '0;
            hdr_sel    <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bank_full[rd_ptr] && !tx_busy) begin
                        state    <= REQ;
                        tx_start <= 1'b1;
                    end
                end
                REQ: begin
                    state   <= HDR;
                    hdr_sel <= 1'b0;
                end
                HDR: begin
                    if (tx_data_req) begin
                        if (!hdr_sel) begin
                            tx_data <= bank_idx[rd_ptr][15:8];
                            hdr_sel <= 1'b1;
                        end else begin
                            tx_data <= bank_idx[rd_ptr][7:0];
                            rd_addr <= '0;
                            state   <= PAY;
                        end
                    end
                end
                PAY: begin
                    if (tx_data_req) begin
                        tx_data <= rd_data;
                        rd_addr <= ram_addr;
                        if (rd_addr == LAST_ADDR) begin
                            state <= REL;
                        end
                    end
                end
                REL: begin
                    frame_done <= (bank_idx[rd_ptr] == LAST_LINE);
                    rd_ptr     <= ~rd_ptr;
                    rd_addr    <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (tx_data_req && state != HDR && state != PAY) begin
                tx_data <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_sobel_line_tx_scheduler.sv
// Directed bench for sobel_line_tx_scheduler with a small geometry (16x4).
// Expected payload bytes are queued when a line is driven and popped as served.
module tb_sobel_line_tx_scheduler;

    localparam int W = 16;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        valid = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        sobel = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_data_req = 1'b0;
    logic        tx_start;
    logic [15:0] tx_len;
    logic [7:0]  tx_data;
    logic        line_drop;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int drop_cnt = 0;
    int done_cnt = 0;
    int d0;
    int f0;
    bit seen;
    logic [7:0]  exp_q[$];
    logic [15:0] model_idx = 16'd0;

    sobel_line_tx_scheduler #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .valid       (valid),
        .hsync       (hsync),
        .vsync       (vsync),
        .sobel       (sobel),
        .tx_busy     (tx_busy),
        .tx_data_req (tx_data_req),
        .tx_start    (tx_start),
        .tx_len      (tx_len),
        .tx_data     (tx_data),
        .line_drop   (line_drop),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Count single-cycle status pulses.
    always @(posedge clk) begin
        #1;
        if (line_drop === 1'b1) drop_cnt++;
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        model_idx = 16'd0;
    endtask

    // Drive one line: hsync rise, then npix pixels MSB-first.
    task automatic apply_line(input logic [15:0] pix, input int npix, input bit stored);
        tick();
        hsync = 1'b1;
        valid = 1'b0;
        tick();
        for (int i = 0; i < npix; i++) begin
            valid = 1'b1;
            sobel = pix[15-i];
            tick();
        end
        valid = 1'b0;
        sobel = 1'b0;
        hsync = 1'b0;
        if (stored) begin
            exp_q.push_back(model_idx[15:8]);
            exp_q.push_back(model_idx[7:0]);
            exp_q.push_back(pix[15:8]);
            exp_q.push_back(pix[7:0]);
        end
        model_idx = model_idx + 16'd1;
    endtask

    task automatic wait_start(output bit got);
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            tick();
            if (tx_start === 1'b1) got = 1'b1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("[TB] FAIL tx_start_timeout: observed=0 expected=1");
        end
        if (got) begin
            tick();
            check_output("tx_start_width", {15'd0, tx_start}, 16'd0);
        end
    endtask

    task automatic serve(input int n);
        logic [7:0] e;
        for (int k = 0; k < n; k++) begin
            tx_data_req = 1'b1;
            tick();
            tx_data_req = 1'b0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("tx_data", {8'd0, tx_data}, {8'd0, e});
            end else begin
                check_output("scoreboard_empty", {8'd0, tx_data}, 16'hFFFF);
            end
        end
    endtask

    task automatic flush(input int n);
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic drain();
        bit got;
        wait_start(got);
        if (got) serve(4);
        else flush(4);
    endtask

    task automatic check_reset_values();
        check_output("rst_tx_start", {15'd0, tx_start}, 16'd0);
        check_output("rst_tx_data", {8'd0, tx_data}, 16'd0);
        check_output("rst_line_drop", {15'd0, line_drop}, 16'd0);
        check_output("rst_frame_done", {15'd0, frame_done}, 16'd0);
        check_output("rst_tx_len", tx_len, 16'd4);
    endtask

    initial begin
        tick();
        tick();
        check_reset_values();
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

        // Basic line
        $display("[TB] basic line");
        pulse_vsync();
        d0 = drop_cnt;
        apply_line(16'hAA0F, 16, 1'b1);
        drain();
        repeat (3) tick();
        check_output("basic_no_drop", 16'(drop_cnt - d0), 16'd0);
        tx_data_req = 1'b1;
        tick();
        tx_data_req = 1'b0;
        check_output("idle_req_data", {8'd0, tx_data}, 16'd0);

        // Full frame
        $display("[TB] frame");
        pulse_vsync();
        d0 = drop_cnt;
        f0 = done_cnt;
        for (int n = 0; n < H; n++) begin
            apply_line((n % 2) ? 16'hFFFF : 16'h0000, 16, 1'b1);
            drain();
            repeat (3) tick();
            if (n == H - 2) check_output("frame_done_early", 16'(done_cnt - f0), 16'd0);
        end
        check_output("frame_done_once", 16'(done_cnt - f0), 16'd1);
        check_output("frame_no_drop", 16'(drop_cnt - d0), 16'd0);

        // Backpressure
        $display("[TB] backpressure");
        pulse_vsync();
        d0 = drop_cnt;
        f0 = done_cnt;
        tx_busy = 1'b1;
        apply_line(16'h1234, 16, 1'b1);
        apply_line(16'h8001, 16, 1'b1);
        apply_line(16'hFFFF, 16, 1'b0);
        repeat (3) tick();
        check_output("bp_drop", 16'(drop_cnt - d0), 16'd1);
        tx_busy = 1'b0;
        drain();
        drain();
        apply_line(16'h5A3C, 16, 1'b1);
        drain();
        repeat (3) tick();
        check_output("bp_frame_done", 16'(done_cnt - f0), 16'd1);

        // Short line
        $display("[TB] short line");
        pulse_vsync();
        d0 = drop_cnt;
        apply_line(16'hFFFF, 5, 1'b0);
        apply_line(16'hC3A5, 16, 1'b1);
        drain();
        repeat (2) tick();
        check_output("short_drop", 16'(drop_cnt - d0), 16'd1);

        // Enable low mid-packet
        $display("[TB] enable");
        pulse_vsync();
        d0 = drop_cnt;
        apply_line(16'h0F0F, 16, 1'b1);
        wait_start(seen);
        enable = 1'b0;
        if (seen) serve(4);
        else flush(4);
        apply_line(16'hFFFF, 16, 1'b0);
        repeat (3) tick();
        check_output("enable_drop", 16'(drop_cnt - d0), 16'd1);
        enable = 1'b1;
        apply_line(16'h6699, 16, 1'b1);
        drain();

        // Reset in the middle of the payload
        $display("[TB] reset mid-packet");
        pulse_vsync();
        apply_line(16'hBEEF, 16, 1'b1);
        wait_start(seen);
        if (seen) serve(3);
        else flush(3);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        model_idx = 16'd0;
        tick();
        rst_n = 1'b1;
        tick();
        apply_line(16'h1357, 16, 1'b1);
        drain();
        repeat (3) tick();

        check_output("scoreboard_left", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
